// File: rtl/dec_counter_if.sv
// Control/status bundle for the loadable down-counter.
// Latency: n/a (wires only); status fields are driven from flops inside the counter.
// Backpressure: none; the controller owns load/d/en and the counter never stalls it.
interface dec_counter_if #(
    parameter int WIDTH = 64
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             uflow;

    // Controller side: issues load/enable and watches count and pulses.
    modport master (
        output load, d, en,
        input  q, busy, done, uflow
    );

    // Counter side.
    modport slave (
        input  load, d, en,
        output q, busy, done, uflow
    );
endinterface

// File: rtl/dec_counter.sv
// Loadable down-counter: load a start value, decrement on enable, pulse done at zero.
// Latency: load or decrement visible one cycle after the sampling edge; all outputs are flops.
// Backpressure: none; en is a plain gate, load always wins and restarts the count.
module dec_counter #(
    parameter int WIDTH = 64,
    parameter bit WRAP  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    dec_counter_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             done_r;
    logic             done_nxt;
    logic             uflow_r;
    logic             uflow_nxt;
    logic [WIDTH-1:0] q_dec;

    // Plain modulo-2^WIDTH decrement; the borrow out is intentionally dropped.
    assign q_dec = q_r - ONE;

    // Next-state decode: load has priority, en only matters while counting.
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        done_nxt  = 1'b0;
        uflow_nxt = 1'b0;
        if (bus.load) begin
            q_nxt = bus.d;
            if (bus.d == ZERO) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end else begin
                state_nxt = COUNT;
            end
        end else if (state == COUNT && bus.en) begin
            q_nxt = q_dec;
            if (q_r == ONE) begin
                done_nxt = 1'b1;
                if (!WRAP) begin
                    state_nxt = IDLE;
                end
            end else if (q_r == ZERO) begin
                // Only reachable when wrapping: 0 rolls to all-ones.
                uflow_nxt = 1'b1;
            end
        end
    end

    // State, count and single-cycle pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_r     <= '0;
            done_r  <= 1'b0;
            uflow_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            q_r     <= q_nxt;
            done_r  <= done_nxt;
            uflow_r <= uflow_nxt;
        end
    end

    assign bus.q     = q_r;
    assign bus.busy  = (state == COUNT);
    assign bus.done  = done_r;
    assign bus.uflow = uflow_r;
endmodule

// File: tb/tb_dec_counter.sv
// Bench for dec_counter: three configurations (8/stop, 8/wrap, 64/stop).
// Expected values are pushed when a cycle is driven and popped after the edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_dec_counter;
    logic clk;
    logic rst_n;

    dec_counter_if #(.WIDTH(8))  if0 ();
    dec_counter_if #(.WIDTH(8))  if1 ();
    dec_counter_if #(.WIDTH(64)) if2 ();

    dec_counter #(.WIDTH(8),  .WRAP(1'b0)) u_stop8  (.clk(clk), .rst_n(rst_n), .bus(if0));
    dec_counter #(.WIDTH(8),  .WRAP(1'b1)) u_wrap8  (.clk(clk), .rst_n(rst_n), .bus(if1));
    dec_counter #(.WIDTH(64), .WRAP(1'b0)) u_full64 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] q;
        logic        busy;
        logic        done;
        logic        uflow;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [66:0] observe(input int sel);
        case (sel)
            0:       return {56'd0, if0.q, if0.busy, if0.done, if0.uflow};
            1:       return {56'd0, if1.q, if1.busy, if1.done, if1.uflow};
            default: return {if2.q, if2.busy, if2.done, if2.uflow};
        endcase
    endfunction

    task automatic check_all(input string tag, input int sel, input logic [63:0] q,
                             input logic b, input logic dn, input logic u);
        logic [66:0] o;
        o = observe(sel);
        chk({tag, ".q"},     o[66:3], q);
        chk({tag, ".busy"},  {63'd0, o[2]}, {63'd0, b});
        chk({tag, ".done"},  {63'd0, o[1]}, {63'd0, dn});
        chk({tag, ".uflow"}, {63'd0, o[0]}, {63'd0, u});
    endtask

    // Drive one cycle on instance sel, queue expectation, clock, pop and compare.
    task automatic cyc(input string tag, input int sel, input logic ld, input logic [63:0] dv,
                       input logic e, input logic [63:0] eq, input logic eb, input logic ed,
                       input logic eu);
        exp_t x;
        if0.load = 1'b0; if0.en = 1'b0; if0.d = '0;
        if1.load = 1'b0; if1.en = 1'b0; if1.d = '0;
        if2.load = 1'b0; if2.en = 1'b0; if2.d = '0;
        case (sel)
            0:       begin if0.load = ld; if0.en = e; if0.d = dv[7:0]; end
            1:       begin if1.load = ld; if1.en = e; if1.d = dv[7:0]; end
            default: begin if2.load = ld; if2.en = e; if2.d = dv; end
        endcase
        x.tag = tag; x.sel = sel; x.q = eq; x.busy = eb; x.done = ed; x.uflow = eu;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_all(x.tag, x.sel, x.q, x.busy, x.done, x.uflow);
    endtask

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        if0.load = 1'b0; if0.en = 1'b0; if0.d = '0;
        if1.load = 1'b0; if1.en = 1'b0; if1.d = '0;
        if2.load = 1'b0; if2.en = 1'b0; if2.d = '0;
        #3;
        for (int s = 0; s < 3; s++) check_all("por", s, 64'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a count.
        cyc("rst_ld5", 0, 1'b1, 64'd5, 1'b0, 64'd5, 1'b1, 1'b0, 1'b0);
        if0.en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 0, 64'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_en_idle", 0, 1'b0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0);

        // Basic countdown, stop at zero.
        cyc("bas_ld3", 0, 1'b1, 64'd3, 1'b0, 64'd3, 1'b1, 1'b0, 1'b0);
        cyc("bas_2",   0, 1'b0, 64'd0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
        cyc("bas_1",   0, 1'b0, 64'd0, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        cyc("bas_0",   0, 1'b0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0);
        cyc("bas_hold",0, 1'b0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0);

        // Gapped enable, then load beats en.
        cyc("gap_ld4", 0, 1'b1, 64'd4, 1'b0, 64'd4, 1'b1, 1'b0, 1'b0);
        cyc("gap_3",   0, 1'b0, 64'd0, 1'b1, 64'd3, 1'b1, 1'b0, 1'b0);
        cyc("gap_hold",0, 1'b0, 64'd0, 1'b0, 64'd3, 1'b1, 1'b0, 1'b0);
        cyc("gap_2",   0, 1'b0, 64'd0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
        cyc("gap_ld9", 0, 1'b1, 64'd9, 1'b1, 64'd9, 1'b1, 1'b0, 1'b0);

        // Zero loads in COUNT and in IDLE, back-to-back.
        cyc("zl_ld7",  0, 1'b1, 64'd7, 1'b0, 64'd7, 1'b1, 1'b0, 1'b0);
        cyc("zl_cnt0", 0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        cyc("zl_idl0", 0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        cyc("zl_quiet",0, 1'b0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0);

        // Wrap mode: 1,0,FF,FE and hold.
        cyc("wr_ld1",  1, 1'b1, 64'd1, 1'b0, 64'd1,    1'b1, 1'b0, 1'b0);
        cyc("wr_0",    1, 1'b0, 64'd0, 1'b1, 64'd0,    1'b1, 1'b1, 1'b0);
        cyc("wr_ff",   1, 1'b0, 64'd0, 1'b1, 64'hFF,   1'b1, 1'b0, 1'b1);
        cyc("wr_fe",   1, 1'b0, 64'd0, 1'b1, 64'hFE,   1'b1, 1'b0, 1'b0);
        cyc("wr_hold", 1, 1'b0, 64'd0, 1'b0, 64'hFE,   1'b1, 1'b0, 1'b0);
        cyc("wr_ld0",  1, 1'b1, 64'd0, 1'b1, 64'd0,    1'b0, 1'b1, 1'b0);

        // Full 64-bit width.
        cyc("fw_ld",   2, 1'b1, ALL1,  1'b0, ALL1,        1'b1, 1'b0, 1'b0);
        cyc("fw_fe",   2, 1'b0, 64'd0, 1'b1, ALL1 - 64'd1, 1'b1, 1'b0, 1'b0);
        cyc("fw_fd",   2, 1'b0, 64'd0, 1'b1, ALL1 - 64'd2, 1'b1, 1'b0, 1'b0);
        cyc("fw_fc",   2, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0);
        cyc("fw_ld2",  2, 1'b1, 64'd2, 1'b0, 64'd2,       1'b1, 1'b0, 1'b0);
        cyc("fw_1",    2, 1'b0, 64'd0, 1'b1, 64'd1,       1'b1, 1'b0, 1'b0);
        cyc("fw_0",    2, 1'b0, 64'd0, 1'b1, 64'd0,       1'b0, 1'b1, 1'b0);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
